ps2_note_decoder: RTL
=====================

// Module: ps2_note_decoder
// PURPOSE
//  Receives raw PS/2 keyboard frames (device-to-host), assembles scan codes and turns make/break
//  sequences into the decoded note code consumed by the piano controller.
//  Emits a note index on key press and STOP_CODE (99) on release of the held key.
//  Sits between the PS/2 connector pins and the controller's key-data input.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  iClk cycles with no PS/2 falling edge mid-frame before abort (1 ms @ 50 MHz)
//  STOP_CODE       99     output code meaning "stop playing after current cycle"
// PORTS
//  iClk        in   1  system clock; single clock domain
//  iReset      in   1  asynchronous, active-high reset
//  iPs2_Clk    in   1  raw PS/2 clock pin (asynchronous, idle high)
//  iPs2_Dat    in   1  raw PS/2 data pin (asynchronous, idle high)
//  oPs2_Data   out  8  current decoded note code, held until the next change
//  oValid      out  1  one-cycle pulse when oPs2_Data is updated
//  oFrameErr   out  1  one-cycle pulse on parity/stop-bit error or timeout
// BEHAVIOUR
//  Reset (async, iReset=1): oPs2_Data=STOP_CODE, oValid=0, oFrameErr=0, FSM=IDLE,
//   bit count=0, timeout counter=0, break/ext flags=0, held key=none. Applies mid-frame too.
//  Sync: iPs2_Clk and iPs2_Dat each go through 2 flops; fall = synced clk 1->0 (prev/cur reg).
//  Bits are sampled from synced data on each fall only.
//  Frame FSM: IDLE -(fall & dat=0)-> DATA; DATA shifts 8 bits LSB first (bit cnt 0..7)
//   -> PARITY -> STOP -> IDLE. fall & dat=1 in IDLE is ignored.
//  Parity: odd over 8 data + parity bit. Stop bit must be 1.
//  Bad parity or stop=0: byte discarded, oFrameErr pulses, break/ext flags cleared, FSM->IDLE.
//  Timeout: counter clears on every fall and in IDLE; in DATA/PARITY/STOP it counts.
//   At TIMEOUT_CYCLES-1: FSM->IDLE, partial byte dropped, oFrameErr pulses, flags kept.
//   If a fall arrives in the same cycle, the fall wins and there is no timeout.
//  Byte complete: on the fall that samples a good stop bit; the decode layer acts on the next cycle.
//   oValid/oPs2_Data update exactly 1 cycle after that fall-detect cycle.
//  Decode layer (per good byte):
//   0xE0: set ext flag, no output.  0xF0: set break flag, no output.
//   Any other byte clears both flags after use. Extended (E0-prefixed) codes produce no output.
//   Make map: 1C,1B,23,2B,34,33,3B,42 (A S D F G H J K) -> notes 1..8;
//    1D,24,2C,35,3C (W E T Y U) -> 11..15. Unmapped codes produce no output.
//   Make of mapped key: if the key is already held (typematic repeat), no output.
//    Otherwise oPs2_Data = note, held key = this code, oValid pulses.
//   Break of held key: oPs2_Data = STOP_CODE, held key = none, oValid pulses.
//   Break of any other key: ignored.
//  oValid and oFrameErr are never asserted in the same cycle.
// TESTING
//  1 Reset: assert iReset mid-frame -> outputs 99/0/0 immediately; the next full frame decodes normally.
//  2 Frame 0x1C (A) at 10 kHz PS/2 clk -> oValid 1-cycle pulse, oPs2_Data=1, 1 cycle after the stop-bit fall.
//  3 Sequence 1C,1C,F0,1C -> exactly two oValid pulses: 1, then 99. F0,1B (key not held) -> no pulse.
//  4 Frame 0x1C with parity bit flipped -> oFrameErr pulse, no oValid, oPs2_Data unchanged.
//  5 Stop clocking after 4 data bits for >TIMEOUT_CYCLES -> oFrameErr pulse, FSM IDLE;
//    then a clean 0x42 frame -> oPs2_Data=8.
//  6 E0,75 then E0,F0,75, and unmapped 0x5A -> no oValid. 1D then F0,1D -> 11 then 99.

Source files
------------

// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder
//   Receives raw PS/2 device-to-host frames, assembles scan codes and turns
//   make/break sequences into note codes for the piano controller. A key press
//   emits its note index; releasing the held key emits STOP_CODE.
//
// Ports
//   iClk       in   1  system clock
//   iReset     in   1  asynchronous active-high reset
//   iPs2_Clk   in   1  raw PS/2 clock pin (async, idle high)
//   iPs2_Dat   in   1  raw PS/2 data pin (async, idle high)
//   oPs2_Data  out  8  current note code, held until the next change
//   oValid     out  1  one-cycle pulse when oPs2_Data is updated
//   oFrameErr  out  1  one-cycle pulse on parity/stop error or frame timeout
//   oDbgState  out  2  frame FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
//
// Handshake: oValid is a pure strobe with no ready; the consumer must take
// oPs2_Data in the cycle oValid is high (it also stays stable afterwards).
module ps2_note_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  STOP_CODE      = 8'd99
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iPs2_Clk,
  input  logic       iPs2_Dat,
  output logic [7:0] oPs2_Data,
  output logic       oValid,
  output logic       oFrameErr,
  output logic [1:0] oDbgState
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Two-flop synchronizers plus a previous-value register for edge detect
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fall;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= iPs2_Clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= iPs2_Dat;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  // Frame layer state
  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          byte_ok;    // good byte completes this cycle (in shift_q)
  logic          bad_frame;  // parity or stop-bit failure this cycle
  logic          timed_out;

  // Decode layer state
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       held_vld_q, held_vld_d;
  logic [7:0] held_q, held_d;
  logic [7:0] note;

  function automatic logic [7:0] note_of(input logic [7:0] code);
    case (code)
      8'h1C:   note_of = 8'd1;
      8'h1B:   note_of = 8'd2;
      8'h23:   note_of = 8'd3;
      8'h2B:   note_of = 8'd4;
      8'h34:   note_of = 8'd5;
      8'h33:   note_of = 8'd6;
      8'h3B:   note_of = 8'd7;
      8'h42:   note_of = 8'd8;
      8'h1D:   note_of = 8'd11;
      8'h24:   note_of = 8'd12;
      8'h2C:   note_of = 8'd13;
      8'h35:   note_of = 8'd14;
      8'h3C:   note_of = 8'd15;
      default: note_of = 8'd0;  // 0 marks an unmapped code
    endcase
  endfunction

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      data_q     <= STOP_CODE;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      held_vld_q <= 1'b0;
      held_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      held_vld_q <= held_vld_d;
      held_q     <= held_d;
    end
  end

  // Frame FSM: next state, shifting, parity/stop check, timeout
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    byte_ok   = 1'b0;
    bad_frame = 1'b0;
    timed_out = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        // A fall with data high is noise, not a start bit
        if (fall && !dat_s2_q) begin
          state_d  = S_DATA;
          bitcnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          // Odd parity: data bits plus parity bit must hold an odd count of ones
          if (dat_s2_q && (^{shift_q, par_q})) byte_ok   = 1'b1;
          else                                 bad_frame = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Mid-frame timeout; a fall in the same cycle always takes precedence
    if (state_q != S_IDLE) begin
      if (fall) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        state_d   = S_IDLE;
        tmo_d     = '0;
        timed_out = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Decode layer: prefixes, make/break against the held key
  always_comb begin
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = bad_frame | timed_out;
    ext_d      = ext_q;
    brk_d      = brk_q;
    held_vld_d = held_vld_q;
    held_d     = held_q;
    note       = note_of(shift_q);

    if (bad_frame) begin
      // A corrupted byte may have been the key after a prefix, so drop prefixes
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_ok) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!ext_q && (note != 8'd0)) begin
          if (brk_q) begin
            if (held_vld_q && (held_q == shift_q)) begin
              data_d     = STOP_CODE;
              held_vld_d = 1'b0;
              valid_d    = 1'b1;
            end
          end else if (!(held_vld_q && (held_q == shift_q))) begin
            // New key press; a repeat of the held key (typematic) is silent
            data_d     = note;
            held_d     = shift_q;
            held_vld_d = 1'b1;
            valid_d    = 1'b1;
          end
        end
      end
    end
  end

  assign oPs2_Data = data_q;
  assign oValid    = valid_q;
  assign oFrameErr = err_q;
  assign oDbgState = state_q;

endmodule
